matrix_bram_ctrl: RTL and testbench
===================================

# matrix_bram_ctrl

Sequencer that drives the 2x2 8-bit `matrix` multiplier from block RAM. On `start` it fetches packed A and B operand words from BRAM, presents them to the multiplier, captures the packed result and writes it back to BRAM, repeating for `count` consecutive matrix pairs. It sits between the BRAM and the reconfigurable multiplier partition. It owns the BRAM port and the multiplier's operand/result interface.

## Interface
- `ADDR_W`, 10: BRAM word address width; `count` uses the same width.
- `clk`  in  1  rising-edge clock for all state.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a job; sampled only in IDLE.
- `base_a`  in  ADDR_W  word address of first A operand.
- `base_b`  in  ADDR_W  word address of first B operand.
- `base_res`  in  ADDR_W  word address of first result.
- `count`  in  ADDR_W  number of matrix pairs, 0..2^ADDR_W-1.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at job end.
- `bram_en`  out  1  BRAM access enable.
- `bram_we`  out  1  BRAM write enable; only ever high together with `bram_en`.
- `bram_addr`  out  ADDR_W  BRAM word address.
- `bram_wdata`  out  32  write data.
- `bram_rdata`  in  32  read data, valid exactly 1 cycle after a read-enable cycle.
- `mat_a`, `mat_b`  out  32  packed operands {m00,m01,m10,m11}, 8 bits each.
- `mat_res`  in  32  packed product from the multiplier, combinational from `mat_a`/`mat_b`.
- `cycles`  out  32  busy-cycle count; see Configuration.

## Operation
- `base_a`, `base_b`, `base_res` and `count` are latched when `start` is accepted. Later changes have no effect on the running job.
- Job index `idx` starts at 0. The address for pair `idx` is base + `idx`, modulo 2^ADDR_W (wrap-around, no error).
- FSM states: IDLE, RD_A, RD_B, CAP_B, CALC, WR, DONE.
  - IDLE: if `start`=1 and `count`≠0, go to RD_A. If `start`=1 and `count`=0, go to DONE with no BRAM access.
  - RD_A: `bram_en`=1, `bram_addr`=base_a+idx.
  - RD_B: `bram_en`=1, `bram_addr`=base_b+idx; register `bram_rdata` into `mat_a`.
  - CAP_B: register `bram_rdata` into `mat_b`.
  - CALC: register `mat_res` into the internal result register.
  - WR: `bram_en`=1, `bram_we`=1, `bram_addr`=base_res+idx, `bram_wdata`=result register.
    - If `idx`=count−1, go to DONE.
    - Otherwise increment `idx` and go to RD_A.
  - DONE: `done`=1, then go to IDLE.
- `start` is ignored while `busy`; there is no queuing.
- Arithmetic (inside the multiplier) is modulo 256 per element. This block passes words through unmodified.
- Reset: from any state, go to IDLE.
  - All outputs are 0: `busy`, `done`, `bram_en`, `bram_we`, `bram_addr`, `bram_wdata`, `mat_a`, `mat_b`, `cycles`.
  - A write that was pending is not issued.
- `bram_en`, `bram_we` and `done` are registered, glitch-free decodes of the state.

## Timing
- `start` is sampled at edge t. RD_A occupies cycle t+1 and `busy` rises in t+1.
- Each pair takes 5 cycles (RD_A..WR). WR of pair n falls in cycle t+5(n+1).
- `done` is high in cycle t+5·count+1. `busy` falls the following cycle.
- With `count`=0, `done` is high in cycle t+1.
- A new `start` may be accepted in the first IDLE cycle after DONE.

## Configuration
- `MATRIX_BRAM_CTRL_PERF_EN` defined:
  - `cycles` clears when a `start` is accepted, then increments once for every cycle `busy` is high.
  - It holds its value after DONE until the next accepted start or `rst`.
- Not defined: `cycles` is tied to 0 and no counter logic is generated.

## Test plan
- Single pair, count=1:
  - Setup: A at base_a holds 0x01020304; B holds 0x05060708.
  - Required: one write of 0x13162B32 to base_res; `done` exactly 6 cycles after `start`.
- Overflow, count=1: A=B=0xFFFFFFFF → written result 0x02020202.
- Burst, count=3:
  - Setup: base_a=0x3FE, base_b=0x100, base_res=0x200.
  - Required: A is read from 0x3FE, 0x3FF, 0x000 (address wrap); results land at 0x200..0x202.
  - Required: `done` 16 cycles after `start`; with PERF_EN, `cycles`=16.
- count=0: `done` arrives 1 cycle after `start`; `bram_en` never asserts.
- `start` held high throughout a count=2 job: exactly one job runs, and a second job begins in the IDLE cycle after DONE.
- `rst` asserted in the CALC cycle of pair 0:
  - Required: no write occurs; all outputs are 0 on the next cycle.
  - Required: a subsequent count=1 job completes correctly.

Source files
------------

// File: rtl/matrix_bram_ctrl.sv
// BRAM sequencer feeding the 2x2 8-bit matrix multiplier, count pairs per job.
// Define MATRIX_BRAM_CTRL_PERF_EN to build the busy-cycle counter on cycles.
module matrix_bram_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_res,
  input  logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              done,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wdata,
  input  logic [31:0]       bram_rdata,
  output logic [31:0]       mat_a,
  output logic [31:0]       mat_b,
  input  logic [31:0]       mat_res,
  output logic [31:0]       cycles
);

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_B, CAP_B, CALC, WR, DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] a_q, b_q, r_q, cnt_q, idx;
  logic [31:0]       res_q;
  logic              last;
  logic              accept;

  assign last   = (idx == cnt_q - 1'b1);
  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (count != '0) ? RD_A : DONE;
      RD_A:    state_nxt = RD_B;
      RD_B:    state_nxt = CAP_B;
      CAP_B:   state_nxt = CALC;
      CALC:    state_nxt = WR;
      WR:      state_nxt = last ? DONE : RD_A;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      bram_en <= 1'b0;
      bram_we <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      idx     <= '0;
      mat_a   <= '0;
      mat_b   <= '0;
      res_q   <= '0;
    end else begin
      busy    <= (state_nxt != IDLE);
      done    <= (state_nxt == DONE);
      bram_en <= (state_nxt inside {RD_A, RD_B, WR});
      bram_we <= (state_nxt == WR);
      if (accept) begin
        a_q   <= base_a;
        b_q   <= base_b;
        r_q   <= base_res;
        cnt_q <= count;
        idx   <= '0;
      end
      if (state == WR && !last) idx <= idx + 1'b1;
      if (state == RD_B)  mat_a <= bram_rdata;
      if (state == CAP_B) mat_b <= bram_rdata;
      if (state == CALC)  res_q <= mat_res;
    end
  end

  always_comb begin
    bram_addr  = '0;
    bram_wdata = '0;
    unique case (state)
      RD_A:    bram_addr = a_q + idx;
      RD_B:    bram_addr = b_q + idx;
      WR: begin
        bram_addr  = r_q + idx;
        bram_wdata = res_q;
      end
      default: bram_addr = '0;
    endcase
  end

`ifdef MATRIX_BRAM_CTRL_PERF_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk) begin
    if (rst)         cyc_q <= '0;
    else if (accept) cyc_q <= '0;
    else if (busy)   cyc_q <= cyc_q + 32'd1;
  end

  assign cycles = cyc_q;
`else
  assign cycles = '0;
`endif

endmodule

// File: tb/tb_matrix_bram_ctrl.sv
// Randomised self-checking bench for matrix_bram_ctrl.
// Models BRAM and the multiplier; compares against a job-level reference.
module tb_matrix_bram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_a = '0, base_b = '0, base_res = '0, count = '0;
  logic        busy, done, bram_en, bram_we;
  logic [9:0]  bram_addr;
  logic [31:0] bram_wdata, bram_rdata, mat_a, mat_b, mat_res, cycles;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem  [1024];
  logic [31:0] snap [1024];
  logic [9:0]  wr_addr [$];
  logic [31:0] wr_data [$];
  logic [9:0]  rd_addr [$];
  logic [9:0]  exp_addr [$];
  logic [31:0] exp_data [$];
  int          done_lat, busy_cnt;
  logic        busy_after, we_bad;

  always #5 clk = ~clk;

  matrix_bram_ctrl #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_a(base_a), .base_b(base_b),
    .base_res(base_res), .count(count),
    .busy(busy), .done(done),
    .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata),
    .mat_a(mat_a), .mat_b(mat_b), .mat_res(mat_res),
    .cycles(cycles)
  );

  function automatic logic [31:0] mmul(
    input logic [31:0] a, input logic [31:0] b);
    int a00, a01, a10, a11, b00, b01, b10, b11;
    logic [7:0] c00, c01, c10, c11;
    a00 = a[31:24]; a01 = a[23:16]; a10 = a[15:8]; a11 = a[7:0];
    b00 = b[31:24]; b01 = b[23:16]; b10 = b[15:8]; b11 = b[7:0];
    c00 = 8'((a00 * b00 + a01 * b10) % 256);
    c01 = 8'((a00 * b01 + a01 * b11) % 256);
    c10 = 8'((a10 * b00 + a11 * b10) % 256);
    c11 = 8'((a10 * b01 + a11 * b11) % 256);
    return {c00, c01, c10, c11};
  endfunction

  assign mat_res = mmul(mat_a, mat_b);

  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_wdata;
      else         bram_rdata <= mem[bram_addr];
    end
  end

  function automatic int exp_cycles(input int cnt);
`ifdef MATRIX_BRAM_CTRL_PERF_EN
    return 5 * cnt + 1;
`else
    return 0;
`endif
  endfunction

  task automatic model_job(input logic [9:0] ba, bb, br, input int cnt);
    logic [31:0] r;
    exp_addr.delete();
    exp_data.delete();
    snap = mem;
    for (int i = 0; i < cnt; i++) begin
      r = mmul(snap[10'(ba + 10'(i))], snap[10'(bb + 10'(i))]);
      exp_addr.push_back(10'(br + 10'(i)));
      exp_data.push_back(r);
      snap[10'(br + 10'(i))] = r;
    end
  endtask

  task automatic do_job(input logic [9:0] ba, bb, br, cnt,
                        input bit scramble);
    @(negedge clk);
    base_a = ba; base_b = bb; base_res = br; count = cnt;
    start = 1'b1;
    @(posedge clk);
    wr_addr.delete(); wr_data.delete(); rd_addr.delete();
    done_lat = -1; busy_cnt = 0; we_bad = 1'b0;
    for (int k = 1; k <= 5 * int'(cnt) + 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (scramble) begin
        base_a = 10'($urandom); base_b = 10'($urandom);
        base_res = 10'($urandom); count = 10'($urandom);
      end
      if (bram_we && !bram_en) we_bad = 1'b1;
      if (bram_en && bram_we) begin
        wr_addr.push_back(bram_addr);
        wr_data.push_back(bram_wdata);
      end
      if (bram_en && !bram_we) rd_addr.push_back(bram_addr);
      if (busy) busy_cnt++;
      if (done) begin
        done_lat = k;
        break;
      end
    end
    @(negedge clk);
    busy_after = busy;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, bram_en, bram_we} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b want 0000",
               {busy, done, bram_en, bram_we});
    end
    checks++;
    if ({bram_addr, bram_wdata, mat_a, mat_b, cycles} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h %h %h want 0",
               bram_addr, bram_wdata, mat_a, mat_b, cycles);
    end
    rst = 1'b0;
  endtask

  task automatic test_single;
    mem[10'h010] = 32'h01020304;
    mem[10'h020] = 32'h05060708;
    do_job(10'h010, 10'h020, 10'h030, 10'd1, 1'b0);
    checks++;
    if (wr_addr.size() !== 1 || wr_addr[0] !== 10'h030
        || wr_data[0] !== 32'h13162B32) begin
      errors++;
      $display("FAIL single_wr got n=%0d %h want 1 13162b32",
               wr_addr.size(), wr_data.size() ? wr_data[0] : 32'h0);
    end
    checks++;
    if (done_lat !== 6) begin
      errors++;
      $display("FAIL single_done got %0d want 6", done_lat);
    end
    checks++;
    if (mem[10'h030] !== 32'h13162B32) begin
      errors++;
      $display("FAIL single_mem got %h want 13162b32", mem[10'h030]);
    end
  endtask

  task automatic test_overflow;
    mem[10'h040] = 32'hFFFFFFFF;
    mem[10'h041] = 32'hFFFFFFFF;
    do_job(10'h040, 10'h041, 10'h042, 10'd1, 1'b0);
    checks++;
    if (wr_data.size() !== 1 || wr_data[0] !== 32'h02020202) begin
      errors++;
      $display("FAIL ovf_wr got n=%0d %h want 02020202",
               wr_data.size(), wr_data.size() ? wr_data[0] : 32'h0);
    end
  endtask

  task automatic test_burst_wrap;
    model_job(10'h3FE, 10'h100, 10'h200, 3);
    do_job(10'h3FE, 10'h100, 10'h200, 10'd3, 1'b0);
    checks++;
    if (rd_addr.size() !== 6 || rd_addr[0] !== 10'h3FE
        || rd_addr[2] !== 10'h3FF || rd_addr[4] !== 10'h000) begin
      errors++;
      $display("FAIL burst_rd got n=%0d want 6 reads 3fe 3ff 000",
               rd_addr.size());
    end
    checks++;
    if (wr_addr.size() !== 3) begin
      errors++;
      $display("FAIL burst_nwr got %0d want 3", wr_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        checks++;
        if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
          errors++;
          $display("FAIL burst_wr%0d got %h:%h want %h:%h", i,
                   wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    checks++;
    if (done_lat !== 16) begin
      errors++;
      $display("FAIL burst_done got %0d want 16", done_lat);
    end
    checks++;
    if (cycles !== 32'(exp_cycles(3))) begin
      errors++;
      $display("FAIL burst_cycles got %0d want %0d",
               cycles, exp_cycles(3));
    end
  endtask

  task automatic test_count_zero;
    do_job(10'h055, 10'h066, 10'h077, 10'd0, 1'b0);
    checks++;
    if (done_lat !== 1) begin
      errors++;
      $display("FAIL zero_done got %0d want 1", done_lat);
    end
    checks++;
    if (rd_addr.size() + wr_addr.size() !== 0) begin
      errors++;
      $display("FAIL zero_bram got %0d accesses want 0",
               rd_addr.size() + wr_addr.size());
    end
    checks++;
    if (busy_after !== 1'b0 || cycles !== 32'(exp_cycles(0))) begin
      errors++;
      $display("FAIL zero_tail got busy=%b cyc=%0d want 0 %0d",
               busy_after, cycles, exp_cycles(0));
    end
  endtask

  task automatic test_random;
    logic [9:0] ba, bb, br;
    int cnt;
    for (int j = 0; j < 8; j++) begin
      ba = 10'($urandom); bb = 10'($urandom); br = 10'($urandom);
      cnt = $urandom_range(1, 7);
      model_job(ba, bb, br, cnt);
      do_job(ba, bb, br, 10'(cnt), 1'b1);
      checks++;
      if (wr_addr.size() !== cnt) begin
        errors++;
        $display("FAIL rnd%0d_nwr got %0d want %0d",
                 j, wr_addr.size(), cnt);
      end else begin
        foreach (exp_addr[i]) begin
          checks++;
          if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
            errors++;
            $display("FAIL rnd%0d_wr%0d got %h:%h want %h:%h", j, i,
                     wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
          end
        end
      end
      checks++;
      if (done_lat !== 5 * cnt + 1 || busy_cnt !== done_lat
          || busy_after !== 1'b0 || we_bad !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d_tim got lat=%0d busy=%0d tail=%b we=%b want %0d",
                 j, done_lat, busy_cnt, busy_after, we_bad, 5 * cnt + 1);
      end
      checks++;
      if (cycles !== 32'(exp_cycles(cnt))) begin
        errors++;
        $display("FAIL rnd%0d_cycles got %0d want %0d",
                 j, cycles, exp_cycles(cnt));
      end
    end
  endtask

  task automatic test_start_held;
    int nwr, lat;
    logic ok12, ok13;
    @(negedge clk);
    base_a = 10'h123; base_b = 10'h234; base_res = 10'h345; count = 10'd2;
    start = 1'b1;
    @(posedge clk);
    nwr = 0; lat = -1; ok12 = 1'b0; ok13 = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (bram_en && bram_we) nwr++;
      if (done && lat < 0) lat = k;
      if (k == 12) ok12 = !busy && !bram_en;
      if (k == 13)
        ok13 = busy && bram_en && !bram_we && bram_addr == 10'h123;
    end
    start = 1'b0;
    checks++;
    if (lat !== 11 || nwr !== 2) begin
      errors++;
      $display("FAIL held_job got lat=%0d wr=%0d want 11 2", lat, nwr);
    end
    checks++;
    if (ok12 !== 1'b1 || ok13 !== 1'b1) begin
      errors++;
      $display("FAIL held_restart got idle=%b rd_a=%b want 1 1", ok12, ok13);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic busy4;
    mem[10'h301] = 32'hDEADBEEF;
    @(negedge clk);
    base_a = 10'h300; base_b = 10'h302; base_res = 10'h301; count = 10'd2;
    start = 1'b1;
    @(posedge clk);
    repeat (4) @(negedge clk);
    start = 1'b0;
    busy4 = busy;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b1 || {busy, done, bram_en, bram_we} !== 4'b0
        || {bram_addr, bram_wdata, mat_a, mat_b, cycles} !== '0) begin
      errors++;
      $display("FAIL midrst_out got busy4=%b ctl=%b a=%h b=%h want 1 0000 0",
               busy4, {busy, done, bram_en, bram_we}, mat_a, mat_b);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mem[10'h301] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL midrst_nowr got %h want deadbeef", mem[10'h301]);
    end
    model_job(10'h300, 10'h302, 10'h301, 1);
    do_job(10'h300, 10'h302, 10'h301, 10'd1, 1'b0);
    checks++;
    if (wr_data.size() !== 1 || wr_data[0] !== exp_data[0]
        || done_lat !== 6) begin
      errors++;
      $display("FAIL midrst_after got n=%0d lat=%0d want 1 6 data %h",
               wr_data.size(), done_lat, exp_data[0]);
    end
  endtask

  initial begin
    foreach (mem[i]) mem[i] = $urandom;
    bram_rdata = '0;
    test_reset;
    test_single;
    test_overflow;
    test_burst_wrap;
    test_count_zero;
    test_random;
    test_start_held;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
